// File: rtl/transport_send_pkg.sv
// rtl/transport_send_pkg.sv - shared constants and FSM state type for the transport layer
package transport_send_pkg;

    localparam logic [7:0] HDR_CTRL  = 8'h40;
    localparam logic [7:0] HDR_AUDIO = 8'h80;

    localparam logic [1:0] SS_CTRL  = 2'b01;
    localparam logic [1:0] SS_AUDIO = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        CTRL_HI,
        CTRL_LO,
        AUD_HI,
        AUD_LO,
        PAD
    } state_t;

endpackage

// File: rtl/tx_word_fifo.sv
// rtl/tx_word_fifo.sv - first-word-fall-through word FIFO with occupancy count
module tx_word_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CW-1:0]    o_count,
    output logic             o_full
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    // A push into a full FIFO still lands when the same cycle frees a slot.
    assign w_pop_ok  = i_pop && (r_count != '0);
    assign w_push_ok = i_push && ((r_count != FULL_C) || w_pop_ok);

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = (r_count == FULL_C);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/transport_send.sv
// rtl/transport_send.sv - packetises session control/audio words into fixed-size byte packets
module transport_send
    import transport_send_pkg::*;
#(
    parameter int PACKET_SIZE = 16,
    parameter int AUDIO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sessionSignal,
    input  logic [15:0] dataIn,
    input  logic        networkBusy,
    output logic        sendSignal,
    output logic [7:0]  packetOut,
    output logic        transportBusy,
    output logic        overflow
);

    localparam int SAMPLES = (PACKET_SIZE - 1) / 2;
    localparam int IW      = $clog2(PACKET_SIZE);
    localparam int WW      = $clog2(SAMPLES);
    localparam int CW      = $clog2(AUDIO_DEPTH + 1);

    localparam logic [IW-1:0] LAST_IDX  = IW'(PACKET_SIZE - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(SAMPLES - 1);
    localparam logic [CW-1:0] SAMPLES_C = CW'(SAMPLES);
    localparam logic [CW-1:0] BUSY_LVL  = CW'(AUDIO_DEPTH - 1);

    state_t        r_state, w_next_state;
    logic [IW-1:0] r_idx, w_idx_next;
    logic [WW-1:0] r_word, w_word_next;
    logic          r_audio, w_audio_next;
    logic          r_ctrl_pending;
    logic [15:0]   r_ctrl_word;
    logic          r_overflow;
    logic          r_send;
    logic [7:0]    r_packet;

    logic          w_emit;
    logic [7:0]    w_byte;
    logic          w_pop;
    logic          w_clr_ctrl;
    logic          w_ctrl_strobe;
    logic          w_aud_strobe;
    logic [15:0]   w_fifo_data;
    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_full;

    assign w_ctrl_strobe = (sessionSignal == SS_CTRL);
    assign w_aud_strobe  = (sessionSignal == SS_AUDIO);

    tx_word_fifo #(
        .DEPTH (AUDIO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_aud_strobe),
        .i_push_data (dataIn),
        .i_pop       (w_pop),
        .o_rd_data   (w_fifo_data),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full)
    );

    always_comb begin
        w_next_state = r_state;
        w_idx_next   = r_idx;
        w_word_next  = r_word;
        w_audio_next = r_audio;
        w_emit       = 1'b0;
        w_byte       = 8'h00;
        w_pop        = 1'b0;
        w_clr_ctrl   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_ctrl_pending) begin
                    w_next_state = HEADER;
                    w_audio_next = 1'b0;
                    w_idx_next   = '0;
                end else if (w_fifo_count >= SAMPLES_C) begin
                    w_next_state = HEADER;
                    w_audio_next = 1'b1;
                    w_idx_next   = '0;
                end
            end
            HEADER: if (!networkBusy) begin
                w_emit       = 1'b1;
                w_byte       = r_audio ? HDR_AUDIO : HDR_CTRL;
                w_word_next  = '0;
                w_next_state = r_audio ? AUD_HI : CTRL_HI;
            end
            CTRL_HI: if (!networkBusy) begin
                w_emit       = 1'b1;
                w_byte       = r_ctrl_word[15:8];
                w_next_state = CTRL_LO;
            end
            CTRL_LO: if (!networkBusy) begin
                w_emit       = 1'b1;
                w_byte       = r_ctrl_word[7:0];
                w_clr_ctrl   = 1'b1;
                w_next_state = PAD;
            end
            AUD_HI: if (!networkBusy) begin
                w_emit       = 1'b1;
                w_byte       = w_fifo_data[15:8];
                w_next_state = AUD_LO;
            end
            AUD_LO: if (!networkBusy) begin
                w_emit = 1'b1;
                w_byte = w_fifo_data[7:0];
                w_pop  = 1'b1;
                if (r_word == LAST_WORD) begin
                    // Odd packet sizes leave no room for padding after the last sample.
                    w_next_state = (r_idx == LAST_IDX) ? IDLE : PAD;
                end else begin
                    w_word_next  = r_word + 1'b1;
                    w_next_state = AUD_HI;
                end
            end
            PAD: if (!networkBusy) begin
                w_emit = 1'b1;
                w_byte = 8'h00;
                if (r_idx == LAST_IDX) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        if (w_emit) w_idx_next = r_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_word  <= '0;
            r_audio <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_idx_next;
            r_word  <= w_word_next;
            r_audio <= w_audio_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_send         <= 1'b0;
            r_packet       <= 8'h00;
            r_ctrl_pending <= 1'b0;
            r_ctrl_word    <= 16'h0000;
            r_overflow     <= 1'b0;
        end else begin
            r_send <= w_emit;
            if (w_emit) r_packet <= w_byte;
            if (w_clr_ctrl) r_ctrl_pending <= 1'b0;
            if (w_ctrl_strobe && !r_ctrl_pending) begin
                r_ctrl_pending <= 1'b1;
                r_ctrl_word    <= dataIn;
            end
            if ((w_ctrl_strobe && r_ctrl_pending) || (w_aud_strobe && w_fifo_full && !w_pop)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign sendSignal    = r_send;
    assign packetOut     = r_packet;
    assign overflow      = r_overflow;
    assign transportBusy = r_ctrl_pending || (w_fifo_count >= BUSY_LVL);

endmodule

// File: tb/tb_transport_send.sv
// tb/tb_transport_send.sv - randomized self-checking bench for transport_send
module tb_transport_send;

    localparam int P  = 16;
    localparam int AD = 16;
    localparam int S  = (P - 1) / 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  sessionSignal = 2'b00;
    logic [15:0] dataIn = 16'h0000;
    logic        networkBusy = 1'b0;
    logic        sendSignal;
    logic [7:0]  packetOut;
    logic        transportBusy;
    logic        overflow;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int nb_viol = 0;
    logic nb_prev = 1'b0;

    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    transport_send #(.PACKET_SIZE(P), .AUDIO_DEPTH(AD)) dut (
        .clk           (clk),
        .reset         (reset),
        .sessionSignal (sessionSignal),
        .dataIn        (dataIn),
        .networkBusy   (networkBusy),
        .sendSignal    (sendSignal),
        .packetOut     (packetOut),
        .transportBusy (transportBusy),
        .overflow      (overflow)
    );

    always @(negedge clk) begin
        cyc++;
        if (sendSignal === 1'b1) begin
            rx_q.push_back(packetOut);
            rx_cyc.push_back(cyc);
            if (nb_prev) nb_viol++;
        end
        nb_prev = networkBusy;
    end

    function automatic void model_ctrl(input logic [15:0] w);
        exp_q.push_back(8'h40);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        for (int k = 3; k < P; k++) exp_q.push_back(8'h00);
    endfunction

    function automatic void model_audio(input logic [15:0] ws[$]);
        logic [15:0] w;
        exp_q.push_back(8'h80);
        for (int k = 0; k < S; k++) begin
            w = ws[k];
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
        for (int k = 1 + 2 * S; k < P; k++) exp_q.push_back(8'h00);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        rx_q.delete();
        rx_cyc.delete();
        exp_q.delete();
        nb_viol = 0;
    endtask

    task automatic strobe(input logic [1:0] kind, input logic [15:0] d);
        for (int k = 0; k < 200 && transportBusy === 1'b1; k++) idle(1);
        sessionSignal = kind;
        dataIn        = d;
        idle(1);
        sessionSignal = 2'b00;
    endtask

    task automatic wait_bytes(input int n, input int mode);
        for (int k = 0; k < 600 && rx_q.size() < n; k++) begin
            @(posedge clk);
            #1;
            case (mode)
                1:       networkBusy = ~networkBusy;
                2:       networkBusy = ($urandom_range(0, 2) == 0);
                default: networkBusy = 1'b0;
            endcase
        end
        networkBusy = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_reset();
        idle(3);
        n_total++;
        if (sendSignal !== 1'b0 || packetOut !== 8'h00) $display("FAIL reset_out got send=%b byte=%02h need send=0 byte=00", sendSignal, packetOut);
        else n_pass++;
        n_total++;
        if (transportBusy !== 1'b0 || overflow !== 1'b0) $display("FAIL reset_flags got busy=%b ovf=%b need 0 0", transportBusy, overflow);
        else n_pass++;
        reset = 1'b0;
        idle(10);
        n_total++;
        if (rx_q.size() != 0) $display("FAIL reset_quiet got %0d bytes need 0", rx_q.size());
        else n_pass++;
    endtask

    task automatic test_control();
        int mis;
        clear_q();
        strobe(2'b01, 16'hABCD);
        model_ctrl(16'hABCD);
        wait_bytes(P, 0);
        idle(4);
        mis = -1;
        foreach (exp_q[i]) if (mis < 0 && (i >= rx_q.size() || rx_q[i] !== exp_q[i])) mis = i;
        n_total++;
        if (mis >= 0 || rx_q.size() != P) $display("FAIL ctrl_bytes got len=%0d first_bad=%0d need len=%0d all match", rx_q.size(), mis, P);
        else n_pass++;
        n_total++;
        if (rx_q.size() != P || rx_cyc[P-1] - rx_cyc[0] != P - 1) $display("FAIL ctrl_consecutive got non-consecutive strobes need %0d in a row", P);
        else n_pass++;
        n_total++;
        if (overflow !== 1'b0 || transportBusy !== 1'b0) $display("FAIL ctrl_flags got ovf=%b busy=%b need 0 0", overflow, transportBusy);
        else n_pass++;
    endtask

    task automatic test_audio();
        int mis;
        logic [15:0] ws[$];
        clear_q();
        for (int k = 1; k <= S; k++) begin
            ws.push_back(16'(k));
            strobe(2'b10, 16'(k));
        end
        model_audio(ws);
        wait_bytes(P, 0);
        idle(4);
        mis = -1;
        foreach (exp_q[i]) if (mis < 0 && (i >= rx_q.size() || rx_q[i] !== exp_q[i])) mis = i;
        n_total++;
        if (mis >= 0 || rx_q.size() != P) $display("FAIL audio_bytes got len=%0d first_bad=%0d need len=%0d all match", rx_q.size(), mis, P);
        else n_pass++;
        // One word short of a packet must not trigger a send if the FIFO drained fully.
        clear_q();
        ws.delete();
        for (int k = 0; k < S - 1; k++) begin
            ws.push_back(16'($urandom));
            strobe(2'b10, ws[k]);
        end
        idle(30);
        n_total++;
        if (rx_q.size() != 0) $display("FAIL audio_fifo_empty got %0d bytes need 0", rx_q.size());
        else n_pass++;
        ws.push_back(16'($urandom));
        strobe(2'b10, ws[S-1]);
        model_audio(ws);
        wait_bytes(P, 0);
        idle(4);
        mis = -1;
        foreach (exp_q[i]) if (mis < 0 && (i >= rx_q.size() || rx_q[i] !== exp_q[i])) mis = i;
        n_total++;
        if (mis >= 0 || rx_q.size() != P) $display("FAIL audio_rand_bytes got len=%0d first_bad=%0d need len=%0d", rx_q.size(), mis, P);
        else n_pass++;
    endtask

    task automatic test_ctrl_during_audio();
        int mis;
        logic [15:0] ws[$];
        clear_q();
        for (int k = 0; k < S; k++) begin
            ws.push_back(16'($urandom));
            strobe(2'b10, ws[k]);
        end
        model_audio(ws);
        model_ctrl(16'h1234);
        wait_bytes(5, 0);
        strobe(2'b01, 16'h1234);
        wait_bytes(2 * P, 0);
        idle(4);
        mis = -1;
        foreach (exp_q[i]) if (mis < 0 && (i >= rx_q.size() || rx_q[i] !== exp_q[i])) mis = i;
        n_total++;
        if (mis >= 0 || rx_q.size() != 2 * P) $display("FAIL preempt_bytes got len=%0d first_bad=%0d need len=%0d", rx_q.size(), mis, 2 * P);
        else n_pass++;
        n_total++;
        if (rx_q.size() != 2 * P || rx_cyc[P] - rx_cyc[P-1] != 2) $display("FAIL preempt_gap got gap other than one idle cycle need 1");
        else n_pass++;
    endtask

    task automatic test_busy_toggle();
        int mis;
        logic [15:0] w;
        clear_q();
        w = 16'($urandom);
        strobe(2'b01, w);
        model_ctrl(w);
        wait_bytes(P, 1);
        idle(4);
        mis = -1;
        foreach (exp_q[i]) if (mis < 0 && (i >= rx_q.size() || rx_q[i] !== exp_q[i])) mis = i;
        n_total++;
        if (mis >= 0 || rx_q.size() != P) $display("FAIL toggle_bytes got len=%0d first_bad=%0d need len=%0d", rx_q.size(), mis, P);
        else n_pass++;
        n_total++;
        if (nb_viol != 0) $display("FAIL toggle_stall got %0d sends after busy need 0", nb_viol);
        else n_pass++;
    endtask

    task automatic test_random_audio();
        int mis;
        logic [15:0] ws[$];
        for (int it = 0; it < 3; it++) begin
            clear_q();
            ws.delete();
            for (int k = 0; k < S; k++) begin
                ws.push_back(16'($urandom));
                strobe(2'b10, ws[k]);
                idle($urandom_range(0, 2));
            end
            model_audio(ws);
            wait_bytes(P, 2);
            idle(4);
            mis = -1;
            foreach (exp_q[i]) if (mis < 0 && (i >= rx_q.size() || rx_q[i] !== exp_q[i])) mis = i;
            n_total++;
            if (mis >= 0 || rx_q.size() != P || nb_viol != 0) $display("FAIL rand_audio_%0d got len=%0d first_bad=%0d stalls=%0d need len=%0d clean", it, rx_q.size(), mis, nb_viol, P);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int mis;
        logic [15:0] ws[$];
        logic [15:0] w2[$];
        clear_q();
        for (int k = 0; k < 2 * S; k++) begin
            ws.push_back(16'($urandom));
            strobe(2'b10, ws[k]);
        end
        for (int k = S; k < 2 * S; k++) w2.push_back(ws[k]);
        model_audio(ws);
        model_audio(w2);
        wait_bytes(2 * P, 0);
        idle(4);
        mis = -1;
        foreach (exp_q[i]) if (mis < 0 && (i >= rx_q.size() || rx_q[i] !== exp_q[i])) mis = i;
        n_total++;
        if (mis >= 0 || rx_q.size() != 2 * P) $display("FAIL b2b_bytes got len=%0d first_bad=%0d need len=%0d", rx_q.size(), mis, 2 * P);
        else n_pass++;
        n_total++;
        if (rx_q.size() != 2 * P || rx_cyc[P] - rx_cyc[P-1] != 2) $display("FAIL b2b_gap got gap other than one idle cycle need 1");
        else n_pass++;
    endtask

    task automatic test_overflow();
        int mis;
        clear_q();
        sessionSignal = 2'b01;
        dataIn        = 16'h5A5A;
        idle(1);
        dataIn        = 16'hC3C3;
        idle(1);
        sessionSignal = 2'b00;
        model_ctrl(16'h5A5A);
        wait_bytes(P, 0);
        idle(30);
        mis = -1;
        foreach (exp_q[i]) if (mis < 0 && (i >= rx_q.size() || rx_q[i] !== exp_q[i])) mis = i;
        n_total++;
        if (mis >= 0 || rx_q.size() != P) $display("FAIL ovf_bytes got len=%0d first_bad=%0d need len=%0d", rx_q.size(), mis, P);
        else n_pass++;
        n_total++;
        if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b need 1", overflow);
        else n_pass++;
        pulse_reset();
        n_total++;
        if (overflow !== 1'b0) $display("FAIL ovf_cleared got %b need 0", overflow);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int mis;
        logic [15:0] ws[$];
        clear_q();
        for (int k = 0; k < S; k++) strobe(2'b10, 16'($urandom));
        wait_bytes(9, 0);
        reset = 1'b1;
        #1;
        n_total++;
        if (sendSignal !== 1'b0) $display("FAIL midreset_send got %b need 0", sendSignal);
        else n_pass++;
        clear_q();
        idle(3);
        reset = 1'b0;
        idle(30);
        n_total++;
        if (rx_q.size() != 0 || transportBusy !== 1'b0) $display("FAIL midreset_quiet got %0d bytes busy=%b need 0 0", rx_q.size(), transportBusy);
        else n_pass++;
        for (int k = 0; k < S; k++) begin
            ws.push_back(16'($urandom));
            strobe(2'b10, ws[k]);
        end
        model_audio(ws);
        wait_bytes(P, 0);
        idle(4);
        mis = -1;
        foreach (exp_q[i]) if (mis < 0 && (i >= rx_q.size() || rx_q[i] !== exp_q[i])) mis = i;
        n_total++;
        if (mis >= 0 || rx_q.size() != P) $display("FAIL midreset_next got len=%0d first_bad=%0d need len=%0d", rx_q.size(), mis, P);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_control();
        test_audio();
        test_ctrl_during_audio();
        test_busy_toggle();
        test_random_audio();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
